// File: rtl/tmds_pkg.sv
// Shared TMDS symbol types and control-period symbols.
package tmds_pkg;

    localparam int unsigned TMDS_SYMBOL_W    = 10;
    localparam int unsigned PAIRS_PER_SYMBOL = 5;

    typedef logic [TMDS_SYMBOL_W-1:0] tmds_symbol_t;

    // Control symbols indexed by {c1, c0}
    localparam tmds_symbol_t CTRL_00 = 10'b1101010100;
    localparam tmds_symbol_t CTRL_01 = 10'b0010101011;
    localparam tmds_symbol_t CTRL_10 = 10'b0101010100;
    localparam tmds_symbol_t CTRL_11 = 10'b1010101011;

endpackage

// File: rtl/tmds_symbol_fifo.sv
// Small synchronous symbol FIFO with extra-MSB pointers for full/empty detection.
module tmds_symbol_fifo
    import tmds_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [TMDS_SYMBOL_W-1:0] wdata,
    output logic [TMDS_SYMBOL_W-1:0] rdata,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]              wptr_q, rptr_q;
    logic [TMDS_SYMBOL_W-1:0] mem [DEPTH];
    logic                     do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/tmds_gearbox.sv
// Per-lane 10:2 gearbox feeding the DDR output stage; inserts idle symbols on FIFO underrun.
module tmds_gearbox
    import tmds_pkg::*;
#(
    parameter int unsigned              FIFO_DEPTH  = 2,
    parameter logic [TMDS_SYMBOL_W-1:0] IDLE_SYMBOL = CTRL_00
) (
    input  logic                     clock,
    input  logic                     aresetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TMDS_SYMBOL_W-1:0] in_data,
    output logic [1:0]               out_d,
    output logic                     sym_load,
    output logic                     underrun,
    input  logic                     underrun_clr
);

    localparam logic [2:0] LAST_PHASE = 3'(PAIRS_PER_SYMBOL - 1);

    logic [2:0]               phase_q, phase_d;
    logic [7:0]               sreg_q, sreg_d;     // symbol bits [9:2]; [1:0] go out on load
    logic                     armed_q, armed_d;
    logic                     underrun_d;
    logic [1:0]               pair_d;
    logic                     load;
    logic                     fifo_full, fifo_empty, fifo_pop;
    logic [TMDS_SYMBOL_W-1:0] fifo_rdata, sym;

    tmds_symbol_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .aresetn (aresetn),
        .push    (in_valid),
        .pop     (fifo_pop),
        .wdata   (in_data),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready = ~fifo_full;
    assign load     = (phase_q == 3'd0);
    assign fifo_pop = load & ~fifo_empty;
    assign sym      = fifo_empty ? IDLE_SYMBOL : fifo_rdata;

    always_comb begin
        phase_d    = (phase_q == LAST_PHASE) ? 3'd0 : phase_q + 3'd1;
        sreg_d     = load ? sym[TMDS_SYMBOL_W-1:2] : sreg_q;
        armed_d    = armed_q | fifo_pop;
        underrun_d = underrun;
        if (load && fifo_empty && armed_q) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        // Earlier bit of each pair goes in out_d[1] (rising-edge half).
        pair_d = 2'b00;
        case (phase_q)
            3'd0:    pair_d = {sym[0], sym[1]};
            3'd1:    pair_d = {sreg_q[0], sreg_q[1]};
            3'd2:    pair_d = {sreg_q[2], sreg_q[3]};
            3'd3:    pair_d = {sreg_q[4], sreg_q[5]};
            3'd4:    pair_d = {sreg_q[6], sreg_q[7]};
            default: pair_d = 2'b00;
        endcase
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            phase_q  <= 3'd0;
            sreg_q   <= '0;
            armed_q  <= 1'b0;
            underrun <= 1'b0;
            out_d    <= 2'b00;
            sym_load <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            sreg_q   <= sreg_d;
            armed_q  <= armed_d;
            underrun <= underrun_d;
            out_d    <= pair_d;
            sym_load <= load;
        end
    end

endmodule

// File: tb/tb_tmds_gearbox.sv
// Self-checking bench for tmds_gearbox: vector table, directed corner cases, random vs. queue model.
module tb_tmds_gearbox;

    localparam int unsigned DEPTH = 2;
    localparam logic [9:0]  IDLE  = 10'b1101010100;

    logic       clock = 1'b0;
    logic       aresetn;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_data;
    logic [1:0] out_d;
    logic       sym_load;
    logic       underrun;
    logic       underrun_clr;

    always #5 clock = ~clock;

    tmds_gearbox #(
        .FIFO_DEPTH  (DEPTH),
        .IDLE_SYMBOL (IDLE)
    ) dut (
        .clock        (clock),
        .aresetn      (aresetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_d        (out_d),
        .sym_load     (sym_load),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: symbol queue, cycle count since reset release, current symbol.
    logic [9:0] m_q[$];
    int         m_cyc;
    logic [9:0] m_cur;
    logic       m_armed;
    logic       m_ur;
    logic [1:0] m_d;
    logic       m_load;

    task automatic model_reset();
        m_q.delete();
        m_cyc   = 0;
        m_cur   = IDLE;
        m_armed = 1'b0;
        m_ur    = 1'b0;
        m_d     = 2'b00;
        m_load  = 1'b0;
    endtask

    // Drive one clock of inputs, advance the model, compare after the edge.
    task automatic cycle(input logic v, input logic [9:0] d, input logic clr, output logic acc);
        int   ph;
        logic ev;
        in_valid     = v;
        in_data      = d;
        underrun_clr = clr;
        #1;
        check("in_ready_pre", 32'(in_ready), 32'(m_q.size() < DEPTH));
        ph  = m_cyc % 5;
        ev  = 1'b0;
        acc = v && (m_q.size() < DEPTH);
        if (ph == 0) begin
            if (m_q.size() != 0) begin
                m_cur   = m_q.pop_front();
                m_armed = 1'b1;
            end else begin
                ev    = m_armed;
                m_cur = IDLE;
            end
            m_load = 1'b1;
        end else begin
            m_load = 1'b0;
        end
        m_d = {m_cur[2*ph], m_cur[2*ph+1]};
        if (ev)       m_ur = 1'b1;
        else if (clr) m_ur = 1'b0;
        if (acc) m_q.push_back(d);
        m_cyc++;
        @(posedge clock);
        #1;
        check("out_d", 32'(out_d), 32'(m_d));
        check("sym_load", 32'(sym_load), 32'(m_load));
        check("underrun", 32'(underrun), 32'(m_ur));
        check("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
    endtask

    // Asynchronous assert between edges; release on a falling edge.
    task automatic apply_reset();
        aresetn      = 1'b0;
        in_valid     = 1'b0;
        underrun_clr = 1'b0;
        #1;
        check("rst out_d", 32'(out_d), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst underrun", 32'(underrun), 32'd0);
        check("rst sym_load", 32'(sym_load), 32'd0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst hold out_d", 32'(out_d), 32'd0);
        @(negedge clock);
        aresetn = 1'b1;
    endtask

    typedef struct {
        logic       rst;
        logic       v;
        logic [9:0] d;
        logic       clr;
        logic [1:0] exp_d;
        logic       exp_load;
        logic       exp_ur;
    } vec_t;

    vec_t       tbl[27];
    logic [1:0] idle_pairs[5];
    logic [9:0] syms[3];
    int         acc_cyc[3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   idx;

        aresetn      = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        underrun_clr = 1'b0;
        model_reset();

        idle_pairs[0] = 2'b00; idle_pairs[1] = 2'b10; idle_pairs[2] = 2'b10;
        idle_pairs[3] = 2'b10; idle_pairs[4] = 2'b11;

        // Idle after reset: 00,10,10,10,11 with no underrun.
        for (int i = 0; i < 10; i++) begin
            tbl[i] = '{i == 0, 1'b0, 10'h000, 1'b0, idle_pairs[i % 5], (i % 5) == 0, 1'b0};
        end
        // One symbol 0x155 then starve; clear; clear racing a fresh underrun.
        tbl[10] = '{1'b1, 1'b1, 10'h155, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 10'h000, 1'b0, 2'b10, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 10'h000, 1'b0, 2'b10, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 10'h000, 1'b0, 2'b10, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 10'h000, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 10'h000, 1'b0, 2'b10, 1'b1, 1'b0};
        for (int i = 16; i < 20; i++) tbl[i] = '{1'b0, 1'b0, 10'h000, 1'b0, 2'b10, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 10'h000, 1'b0, 2'b00, 1'b1, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 10'h000, 1'b1, 2'b10, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 10'h000, 1'b0, 2'b10, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 1'b0, 10'h000, 1'b0, 2'b10, 1'b0, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 10'h000, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[25] = '{1'b0, 1'b0, 10'h000, 1'b1, 2'b00, 1'b1, 1'b1};
        tbl[26] = '{1'b0, 1'b0, 10'h000, 1'b1, 2'b10, 1'b0, 1'b0};

        #2;
        for (int i = 0; i < 27; i++) begin
            if (tbl[i].rst) apply_reset();
            cycle(tbl[i].v, tbl[i].d, tbl[i].clr, acc);
            check($sformatf("vec%0d out_d", i), 32'(out_d), 32'(tbl[i].exp_d));
            check($sformatf("vec%0d sym_load", i), 32'(sym_load), 32'(tbl[i].exp_load));
            check($sformatf("vec%0d underrun", i), 32'(underrun), 32'(tbl[i].exp_ur));
        end

        // Alternating 0x3FF / 0x000 at exactly one per symbol period.
        apply_reset();
        for (int k = 0; k < 60; k++) begin
            cycle((k % 5) == 0, ((k / 5) % 2) == 0 ? 10'h3FF : 10'h000, 1'b0, acc);
            if (k >= 5) begin
                check("alt pattern", 32'(out_d), ((((k / 5) - 1) % 2) == 0) ? 32'd3 : 32'd0);
            end
        end
        check("alt no underrun", 32'(underrun), 32'd0);

        // Back-pressure: three symbols offered back to back.
        apply_reset();
        syms[0] = 10'h2AB; syms[1] = 10'h0F3; syms[2] = 10'h31C;
        idx = 0;
        for (int k = 0; k < 30; k++) begin
            cycle(idx < 3, (idx < 3) ? syms[idx] : 10'h000, 1'b0, acc);
            if (acc) begin
                acc_cyc[idx] = k;
                idx++;
            end
        end
        check("bp all accepted", 32'(idx), 32'd3);
        if (idx == 3) begin
            check("bp accept0", 32'(acc_cyc[0]), 32'd0);
            check("bp accept1", 32'(acc_cyc[1]), 32'd1);
            check("bp accept2", 32'(acc_cyc[2]), 32'd6);
        end

        // Reset mid-symbol with two entries queued; stale data must never appear.
        apply_reset();
        cycle(1'b1, 10'h3C5, 1'b0, acc);
        cycle(1'b1, 10'h0AA, 1'b0, acc);
        for (int k = 2; k < 6; k++) cycle(1'b0, 10'h000, 1'b0, acc);
        cycle(1'b1, 10'h1E1, 1'b0, acc);
        cycle(1'b0, 10'h000, 1'b0, acc);
        check("pre-reset fifo full", 32'(in_ready), 32'd0);
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 10'h000, 1'b0, acc);
            check("post-reset idle", 32'(out_d), 32'(idle_pairs[k % 5]));
        end
        check("post-reset no underrun", 32'(underrun), 32'd0);

        // Random traffic: heavy (back-pressure) then light (underruns).
        apply_reset();
        for (int k = 0; k < 600; k++) begin
            cycle($urandom_range(0, 99) < ((k < 300) ? 35 : 15), 10'($urandom),
                  $urandom_range(0, 19) == 0, acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
